// File: rtl/alu_seq.sv
// Multi-byte sequencer: runs 16/24/32-bit operations LSB-first on one byte-wide ALU slice.
// Define ALU_SEQ_ABORT_EN to add the abort input that cancels a sequence in flight.
module alu_seq #(
   parameter int WIDTH       = 8,
   parameter int MAX_BYTES   = 4,
   parameter int STEP_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
`ifdef ALU_SEQ_ABORT_EN
   input  logic                           abort,
`endif
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [WIDTH*MAX_BYTES-1:0]     req_lhs,
   input  logic [WIDTH*MAX_BYTES-1:0]     req_rhs,
   input  logic [3:0]                     req_op_first,
   input  logic [3:0]                     req_op_rest,
   input  logic [$clog2(MAX_BYTES+1)-1:0] req_nbytes,
   output logic [WIDTH-1:0]               alu_lhs,
   output logic [WIDTH-1:0]               alu_rhs,
   output logic [3:0]                     alu_operation,
   output logic                           alu_assert_n,
   input  logic [WIDTH-1:0]               alu_result,
   input  logic [4:0]                     alu_flags,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [WIDTH*MAX_BYTES-1:0]     rsp_result,
   output logic [4:0]                     rsp_flags
);
   localparam int NB_W  = $clog2(MAX_BYTES+1);
   localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int TOT_W = WIDTH*MAX_BYTES;

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

   state_t            r_state;
   logic [TOT_W-1:0]  r_lhs;
   logic [TOT_W-1:0]  r_rhs;
   logic [TOT_W-1:0]  r_result;
   logic [3:0]        r_op_rest;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_last_idx;
   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_alu_lhs;
   logic [WIDTH-1:0]  r_alu_rhs;
   logic [3:0]        r_alu_op;
   logic [4:0]        r_flags;
   logic              r_req_ready;
   logic              r_rsp_valid;

   logic [WIDTH-1:0]  w_lhs_byte [MAX_BYTES];
   logic [WIDTH-1:0]  w_rhs_byte [MAX_BYTES];
   logic [IDX_W-1:0]  w_idx_next;
   logic [NB_W-1:0]   w_nb_eff;
   logic              w_step_end;
   logic              w_abort;

   generate
      for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_bytes
         assign w_lhs_byte[gi] = r_lhs[gi*WIDTH +: WIDTH];
         assign w_rhs_byte[gi] = r_rhs[gi*WIDTH +: WIDTH];
      end
   endgenerate

`ifdef ALU_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Out-of-range lengths collapse to a single byte.
   assign w_nb_eff   = (req_nbytes == '0 || req_nbytes > NB_W'(MAX_BYTES)) ? NB_W'(1) : req_nbytes;
   assign w_idx_next = r_idx + 1'b1;
   assign w_step_end = (r_cnt == CNT_W'(STEP_CYCLES-1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_lhs       <= '0;
         r_rhs       <= '0;
         r_result    <= '0;
         r_op_rest   <= '0;
         r_idx       <= '0;
         r_last_idx  <= '0;
         r_cnt       <= '0;
         r_alu_lhs   <= '0;
         r_alu_rhs   <= '0;
         r_alu_op    <= '0;
         r_flags     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else if (w_abort && r_state != S_IDLE) begin
         r_state     <= S_IDLE;
         r_result    <= '0;
         r_flags     <= '0;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_lhs       <= req_lhs;
                  r_rhs       <= req_rhs;
                  r_op_rest   <= req_op_rest;
                  r_last_idx  <= IDX_W'(w_nb_eff - NB_W'(1));
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_result    <= '0;
                  r_flags     <= '0;
                  // Byte 0 goes onto the ALU bus in the same edge as the accept.
                  r_alu_lhs   <= req_lhs[WIDTH-1:0];
                  r_alu_rhs   <= req_rhs[WIDTH-1:0];
                  r_alu_op    <= req_op_first;
                  r_req_ready <= 1'b0;
                  r_state     <= S_STEP;
               end
            end
            S_STEP: begin
               if (w_step_end) begin
                  r_cnt <= '0;
                  r_result[r_idx*WIDTH +: WIDTH] <= alu_result;
                  r_flags <= {alu_flags[4:3], alu_flags[2] & ((r_idx == '0) | r_flags[2]), alu_flags[1:0]};
                  if (r_idx == r_last_idx) begin
                     r_state <= S_DONE;
                  end else begin
                     r_idx     <= w_idx_next;
                     r_alu_lhs <= w_lhs_byte[w_idx_next];
                     r_alu_rhs <= w_rhs_byte[w_idx_next];
                     r_alu_op  <= r_op_rest;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               // The final byte lands one edge before the response is presented.
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready     = r_req_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_result    = r_result;
   assign rsp_flags     = r_flags;
   assign alu_lhs       = r_alu_lhs;
   assign alu_rhs       = r_alu_rhs;
   assign alu_operation = r_alu_op;
   assign alu_assert_n  = 1'b1;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: clocked byte-ALU model with carry latch, wide-arithmetic reference model.
module tb_alu_seq;
   localparam int WIDTH = 8;
   localparam int MAX_BYTES = 4;
   localparam int STEP_CYCLES = 2;
   localparam logic [3:0] OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3, OP_SBC = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5, OP_XOR = 4'd6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_lhs = '0;
   logic [31:0] req_rhs = '0;
   logic [3:0]  req_op_first = '0;
   logic [3:0]  req_op_rest = '0;
   logic [2:0]  req_nbytes = '0;
   logic [7:0]  alu_lhs;
   logic [7:0]  alu_rhs;
   logic [3:0]  alu_operation;
   logic        alu_assert_n;
   logic [7:0]  alu_q = '0;
   logic [4:0]  alu_fq = '0;
   logic        c_latch = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;
`ifdef ALU_SEQ_ABORT_EN
   logic        abort = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(WIDTH), .MAX_BYTES(MAX_BYTES), .STEP_CYCLES(STEP_CYCLES)) dut (
      .clk(clk),
      .reset(reset),
`ifdef ALU_SEQ_ABORT_EN
      .abort(abort),
`endif
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_lhs(req_lhs),
      .req_rhs(req_rhs),
      .req_op_first(req_op_first),
      .req_op_rest(req_op_rest),
      .req_nbytes(req_nbytes),
      .alu_lhs(alu_lhs),
      .alu_rhs(alu_rhs),
      .alu_operation(alu_operation),
      .alu_assert_n(alu_assert_n),
      .alu_result(alu_q),
      .alu_flags(alu_fq),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_result(rsp_result),
      .rsp_flags(rsp_flags)
   );

   // Byte ALU: returns {lcarry, acarry, zero, sign, overflow, result}.
   function automatic logic [12:0] alu_byte(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] t;
      logic lc, ov;
      t = '0; lc = 1'b0; ov = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            t  = {1'b0, a} + {1'b0, b} + {8'd0, (op == OP_ADC) & c};
            ov = (a[7] == b[7]) && (t[7] != a[7]);
         end
         OP_SUB, OP_SBC: begin
            t  = {1'b0, a} + {1'b0, ~b} + {8'd0, (op == OP_SUB) | c};
            ov = (a[7] != b[7]) && (t[7] != a[7]);
         end
         OP_AND: begin t = {1'b0, a & b}; lc = a[7]; end
         OP_XOR: begin t = {1'b0, a ^ b}; lc = a[7]; end
         default: t = '0;
      endcase
      return {lc, t[8], (t[7:0] == 8'd0), t[7], ov, t[7:0]};
   endfunction

   // Registered ALU output; the carry latch follows the registered carry flag.
   always @(posedge clk) begin
      {alu_fq, alu_q} <= alu_byte(alu_operation, alu_lhs, alu_rhs, c_latch);
      c_latch <= alu_fq[3];
   end

   // Whole-word reference: {flags, result} for kind 0 add, 1 sub, 2 and, 3 xor over n bytes.
   function automatic logic [36:0] ref_op(input int kind, input logic [31:0] lv, input logic [31:0] rv, input int n);
      int w;
      logic [63:0] mask, l, r, res;
      logic lc, ac, ov, ml, mr, mres;
      w = 8 * n;
      mask = (64'd1 << w) - 64'd1;
      l = {32'd0, lv} & mask;
      r = {32'd0, rv} & mask;
      lc = 1'b0; ac = 1'b0; ov = 1'b0;
      ml = l[w-1]; mr = r[w-1];
      case (kind)
         0: begin res = l + r; ac = res[w]; res = res & mask; end
         1: begin res = (l - r) & mask; ac = (l >= r); end
         2: begin res = l & r; lc = ml; end
         default: begin res = l ^ r; lc = ml; end
      endcase
      mres = res[w-1];
      if (kind == 0) ov = (ml == mr) && (mres != ml);
      if (kind == 1) ov = (ml != mr) && (mres != ml);
      return {lc, ac, (res == 64'd0), mres, ov, res[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request; cut_kind 1 = reset, 2 = abort at cycle cut_at after accept.
   task automatic do_op(input int kind, input logic [31:0] lv, input logic [31:0] rv, input logic [2:0] nb,
                        input int bp, input int cut_at, input int cut_kind,
                        output logic [31:0] got_res, output logic [4:0] got_flags);
      logic [36:0] exp;
      logic [3:0] opf, opr;
      int n;
      n = (nb == 3'd0 || nb > 3'd4) ? 1 : int'(nb);
      exp = ref_op(kind, lv, rv, n);
      case (kind)
         0: begin opf = OP_ADD; opr = OP_ADC; end
         1: begin opf = OP_SUB; opr = OP_SBC; end
         2: begin opf = OP_AND; opr = OP_AND; end
         default: begin opf = OP_XOR; opr = OP_XOR; end
      endcase
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_lhs = lv; req_rhs = rv;
      req_op_first = opf; req_op_rest = opr; req_nbytes = nb;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 2 * n; c++) begin
         if (cut_kind != 0 && c == cut_at) begin
            if (cut_kind == 1) reset = 1'b1;
`ifdef ALU_SEQ_ABORT_EN
            else abort = 1'b1;
`endif
            @(negedge clk);
            reset = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
            abort = 1'b0;
`endif
            check("cut_req_ready", req_ready, 1);
            check("cut_rsp_valid", rsp_valid, 0);
            check("cut_rsp_result", rsp_result, 0);
            check("cut_rsp_flags", rsp_flags, 0);
            if (cut_kind == 1) begin
               check("rst_alu_lhs", alu_lhs, 0);
               check("rst_alu_rhs", alu_rhs, 0);
               check("rst_alu_op", alu_operation, 0);
               check("rst_assert_n", alu_assert_n, 1);
            end
            for (int k = 0; k < 2 * n + 4; k++) begin
               @(negedge clk);
               check("cut_no_rsp", rsp_valid, 0);
               check("cut_idle_ready", req_ready, 1);
            end
            got_res = rsp_result; got_flags = rsp_flags;
            return;
         end
         check("step_alu_lhs", alu_lhs, (lv >> (8 * (c / 2))) & 32'hFF);
         check("step_alu_rhs", alu_rhs, (rv >> (8 * (c / 2))) & 32'hFF);
         check("step_alu_op", alu_operation, (c < 2) ? opf : opr);
         check("step_assert_n", alu_assert_n, 1);
         check("step_req_ready", req_ready, 0);
         check("step_rsp_valid", rsp_valid, 0);
         @(negedge clk);
      end
      check("latency_not_early", rsp_valid, 0);
      @(negedge clk);
      check("latency_valid", rsp_valid, 1);
      check("rsp_result", rsp_result, exp[31:0]);
      check("rsp_flags", rsp_flags, exp[36:32]);
      check("done_req_ready", req_ready, 0);
      got_res = rsp_result; got_flags = rsp_flags;
      if (bp > 0) req_valid = 1'b1;
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         check("bp_valid", rsp_valid, 1);
         check("bp_result", rsp_result, exp[31:0]);
         check("bp_flags", rsp_flags, exp[36:32]);
         check("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b0;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_req_ready", req_ready, 1);
      $display("op kind=%0d nb=%0d lhs=%08h rhs=%08h -> result=%08h flags=%05b (bp=%0d)",
               kind, nb, lv, rv, got_res, got_flags, bp);
   endtask

   initial begin
      logic [31:0] res;
      logic [4:0] flg;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_req_ready", req_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_alu_lhs", alu_lhs, 0);
      check("reset_alu_rhs", alu_rhs, 0);
      check("reset_alu_op", alu_operation, 0);
      check("reset_assert_n", alu_assert_n, 1);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_rsp_flags", rsp_flags, 0);

      do_op(0, 32'h0000_00FF, 32'h0000_0001, 3'd2, 0, -1, 0, res, flg);
      check("add16_result", res, 32'h0000_0100);
      check("add16_acarry", flg[3], 0);
      check("add16_zero", flg[2], 0);

      do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'd4, 0, -1, 0, res, flg);
      check("add32_result", res, 32'h0000_0000);
      check("add32_zero", flg[2], 1);
      check("add32_acarry", flg[3], 1);

      do_op(0, 32'h1234_567F, 32'hAB00_0001, 3'd0, 0, -1, 0, res, flg);
      check("len0_result", res, 32'h0000_0080);
      check("len0_sign", flg[1], 1);
      check("len0_overflow", flg[0], 1);

      do_op(1, 32'h0000_1000, 32'h0000_2001, 3'd3, 10, -1, 0, res, flg);
      check("bp_sub_result", res, 32'h00FF_EFFF);

      do_op(0, 32'h89AB_CDEF, 32'h1357_9BDF, 3'd4, 0, 2, 1, res, flg);
      do_op(0, 32'h0000_0040, 32'h0000_0041, 3'd1, 0, -1, 0, res, flg);
      check("after_reset_result", res, 32'h0000_0081);

`ifdef ALU_SEQ_ABORT_EN
      do_op(0, 32'h0102_0304, 32'h1111_1111, 3'd4, 0, 4, 2, res, flg);
      do_op(2, 32'h0000_00F0, 32'h0000_003C, 3'd1, 0, -1, 0, res, flg);
      check("after_abort_result", res, 32'h0000_0030);
`endif

      for (int t = 0; t < 16; t++) begin
         do_op(int'($urandom_range(0, 3)), $urandom, $urandom, 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), -1, 0, res, flg);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
